leaf_out_arbiter: RTL and testbench

- Shares the single leaf-to-BFT output link between NUM_PORTS user output streams of one leaf.
- Accepts 32-bit AXI-stream-style words from the user core's Output_N ports.
- Arbitrates round-robin among ports that have valid data, a configured destination and link credit.
- Wraps the winning word into a 49-bit BFT packet carrying destination leaf/port and a per-port sequence address.

---
 rtl/leaf_out_arbiter.sv | 166 ++++++++++++++++
 tb/tb_leaf_out_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/leaf_out_arbiter.sv
// Round-robin arbiter that shares the leaf-to-BFT output link between NUM_PORTS user streams.
// Optional per-port packet and stall statistics are built when LEAF_ARB_STATS_EN is defined.
//
// state | meaning
// IDLE  | stopped, no grants, waiting for ap_start
// RUN   | granting eligible ports into the output register
// DRAIN | ap_start dropped, no grants, waiting for the output register to empty
module leaf_out_arbiter #(
  parameter int PAYLOAD_BITS  = 32,
  parameter int PACKET_BITS   = 49,
  parameter int NUM_PORTS     = 2,
  parameter int NUM_LEAF_BITS = 4,
  parameter int NUM_PORT_BITS = 4,
  parameter int NUM_ADDR_BITS = 7,
  parameter int CREDIT_INIT   = 128,
  parameter int CREDIT_BITS   = 8
) (
  input  logic                              ap_clk,
  input  logic                              ap_rst_n,
  input  logic                              ap_start,
  input  logic [NUM_PORTS*PAYLOAD_BITS-1:0] in_tdata,
  input  logic [NUM_PORTS-1:0]              in_tvalid,
  output logic [NUM_PORTS-1:0]              in_tready,
  output logic [PACKET_BITS-1:0]            pkt_out,
  input  logic                              pkt_rdy,
  input  logic                              cfg_we,
  input  logic [NUM_PORT_BITS-1:0]          cfg_port,
  input  logic [NUM_LEAF_BITS-1:0]          cfg_leaf,
  input  logic [NUM_PORT_BITS-1:0]          cfg_dport,
  input  logic                              credit_vld,
  input  logic [NUM_PORT_BITS-1:0]          credit_port,
  input  logic [CREDIT_BITS-1:0]            credit_cnt,
  output logic                              busy
`ifdef LEAF_ARB_STATS_EN
  ,
  output logic [NUM_PORTS*32-1:0]           stat_pkt_cnt,
  output logic [31:0]                       stat_stall_cnt
`endif
);

  localparam int PTR_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
  localparam logic [CREDIT_BITS:0] CREDIT_MAX = {1'b0, {CREDIT_BITS{1'b1}}};

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  state_t                     state_q;
  logic [PACKET_BITS-1:0]     pkt_q, pkt_d;
  logic [PTR_W-1:0]           rr_q;
  logic [NUM_LEAF_BITS-1:0]   leaf_q   [NUM_PORTS];
  logic [NUM_PORT_BITS-1:0]   dport_q  [NUM_PORTS];
  logic [NUM_ADDR_BITS-1:0]   seq_q    [NUM_PORTS];
  logic [CREDIT_BITS-1:0]     credit_q [NUM_PORTS];
  logic [CREDIT_BITS-1:0]     credit_d [NUM_PORTS];
  logic [NUM_PORTS-1:0]       cfg_en_q;
  logic [NUM_PORTS-1:0]       eligible;
  logic                       space, grant_en, win_vld, accept;
  logic [PTR_W-1:0]           win_idx;

  assign space    = ~pkt_q[PACKET_BITS-1] | pkt_rdy;
  assign grant_en = (state_q == S_RUN) & ap_start & space;
  assign accept   = grant_en & win_vld;
  assign pkt_out  = pkt_q;
  assign busy     = (state_q != S_IDLE) | pkt_q[PACKET_BITS-1];

  always_comb begin
    eligible = '0;
    for (int i = 0; i < NUM_PORTS; i++)
      eligible[i] = in_tvalid[i] & cfg_en_q[i] & (credit_q[i] != '0);
  end

  // Search starts one past the last winner so every port gets a turn.
  always_comb begin : win_sel
    int idx;
    win_vld = 1'b0;
    win_idx = '0;
    idx     = 0;
    for (int k = 1; k <= NUM_PORTS; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
      if (!win_vld && eligible[idx]) begin
        win_vld = 1'b1;
        win_idx = PTR_W'(idx);
      end
    end
  end

  always_comb begin
    in_tready = '0;
    if (accept) in_tready[win_idx] = 1'b1;
  end

  assign pkt_d = {1'b1, leaf_q[win_idx], dport_q[win_idx], seq_q[win_idx], 1'b0,
                  in_tdata[int'(win_idx)*PAYLOAD_BITS +: PAYLOAD_BITS]};

  // Return and consume on the same port net out before saturation.
  always_comb begin : credit_next
    logic [CREDIT_BITS:0] csum;
    csum = '0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      csum = {1'b0, credit_q[i]};
      if (credit_vld && credit_port == NUM_PORT_BITS'(i)) csum = csum + {1'b0, credit_cnt};
      if (accept && win_idx == PTR_W'(i)) csum = csum - (CREDIT_BITS+1)'(1);
      credit_d[i] = (csum > CREDIT_MAX) ? CREDIT_MAX[CREDIT_BITS-1:0] : csum[CREDIT_BITS-1:0];
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q  <= S_IDLE;
      pkt_q    <= '0;
      rr_q     <= PTR_W'(NUM_PORTS-1);
      cfg_en_q <= '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
        leaf_q[i]   <= '0;
        dport_q[i]  <= '0;
        seq_q[i]    <= '0;
        credit_q[i] <= CREDIT_BITS'(CREDIT_INIT);
      end
    end else begin
      case (state_q)
        S_IDLE:  if (ap_start) state_q <= S_RUN;
        S_RUN:   if (!ap_start) state_q <= S_DRAIN;
        S_DRAIN: begin
          if (ap_start) state_q <= S_RUN;
          else if (!pkt_q[PACKET_BITS-1] || pkt_rdy) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase

      if (accept) begin
        pkt_q <= pkt_d;
        rr_q  <= win_idx;
      end else if (pkt_rdy) begin
        pkt_q[PACKET_BITS-1] <= 1'b0;
      end

      for (int i = 0; i < NUM_PORTS; i++) begin
        credit_q[i] <= credit_d[i];
        if (cfg_we && cfg_port == NUM_PORT_BITS'(i)) begin
          leaf_q[i]   <= cfg_leaf;
          dport_q[i]  <= cfg_dport;
          cfg_en_q[i] <= 1'b1;
          seq_q[i]    <= '0;
        end else if (accept && win_idx == PTR_W'(i)) begin
          seq_q[i] <= seq_q[i] + NUM_ADDR_BITS'(1);
        end
      end
    end
  end

`ifdef LEAF_ARB_STATS_EN
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      stat_pkt_cnt   <= '0;
      stat_stall_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_PORTS; i++)
        if (accept && win_idx == PTR_W'(i))
          stat_pkt_cnt[i*32 +: 32] <= stat_pkt_cnt[i*32 +: 32] + 32'd1;
      if (pkt_q[PACKET_BITS-1] && !pkt_rdy)
        stat_stall_cnt <= stat_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_leaf_out_arbiter.sv
// Scoreboard bench for leaf_out_arbiter: directed phases push expected packets, a monitor pops on transfer.
module tb_leaf_out_arbiter;
  localparam int NP = 2;

  logic             ap_clk = 1'b0;
  logic             ap_rst_n, ap_start, pkt_rdy;
  logic [NP*32-1:0] in_tdata;
  logic [NP-1:0]    in_tvalid, in_tready;
  logic [48:0]      pkt_out;
  logic             cfg_we, credit_vld, busy;
  logic [3:0]       cfg_port, cfg_leaf, cfg_dport, credit_port;
  logic [7:0]       credit_cnt;

  leaf_out_arbiter dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .ap_start(ap_start),
    .in_tdata(in_tdata), .in_tvalid(in_tvalid), .in_tready(in_tready),
    .pkt_out(pkt_out), .pkt_rdy(pkt_rdy),
    .cfg_we(cfg_we), .cfg_port(cfg_port), .cfg_leaf(cfg_leaf), .cfg_dport(cfg_dport),
    .credit_vld(credit_vld), .credit_port(credit_port), .credit_cnt(credit_cnt),
    .busy(busy)
  );

  always #5 ap_clk = ~ap_clk;

  int          n_chk = 0;
  int          n_fail = 0;
  logic [48:0] sb_q[$];
  bit          mon_en = 1'b1;
  int          sent[NP];
  int          limit[NP];
  logic [NP-1:0] last_acc;

  function automatic logic [48:0] mkpkt(int leaf, int dport, int seq, logic [31:0] data);
    return {1'b1, 4'(leaf), 4'(dport), 7'(seq), 1'b0, data};
  endfunction

  function automatic logic [31:0] word(int p, int k);
    return 32'hD000_0000 + (32'(p) << 24) + 32'(k);
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge ap_clk) begin
    if (ap_rst_n && mon_en && pkt_out[48] && pkt_rdy) begin
      if (sb_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_pkt: got %0h expected none", pkt_out);
      end else begin
        chk("pkt", 64'(pkt_out), 64'(sb_q.pop_front()));
      end
    end
  end

  task automatic drive_src();
    for (int i = 0; i < NP; i++) begin
      in_tvalid[i]         = sent[i] < limit[i];
      in_tdata[i*32 +: 32] = word(i, sent[i]);
    end
  endtask

  task automatic step();
    @(negedge ap_clk);
    last_acc = in_tvalid & in_tready;
    @(posedge ap_clk);
    #1;
    for (int i = 0; i < NP; i++) if (last_acc[i]) sent[i]++;
    drive_src();
  endtask

  task automatic reset_dut();
    ap_rst_n = 1'b0;
    ap_start = 1'b0; pkt_rdy = 1'b0; cfg_we = 1'b0; credit_vld = 1'b0;
    cfg_port = '0; cfg_leaf = '0; cfg_dport = '0; credit_port = '0; credit_cnt = '0;
    for (int i = 0; i < NP; i++) begin sent[i] = 0; limit[i] = 0; end
    drive_src();
    sb_q.delete();
    repeat (2) @(posedge ap_clk);
    @(negedge ap_clk) ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
  endtask

  task automatic cfg_wr(int p, int leaf, int dport);
    cfg_we = 1'b1; cfg_port = 4'(p); cfg_leaf = 4'(leaf); cfg_dport = 4'(dport);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic end_phase(string name, int budget);
    int n = 0;
    while (sb_q.size() != 0 && n < budget) begin step(); n++; end
    chk({name, "_drained"}, 64'(sb_q.size()), 64'd0);
  endtask

  task automatic wait_valid(int budget);
    int n = 0;
    while (!pkt_out[48] && n < budget) begin step(); n++; end
    chk("wait_valid", 64'(pkt_out[48]), 64'd1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // reset holds outputs low even with live inputs
    ap_rst_n = 1'b0; ap_start = 1'b1; pkt_rdy = 1'b1; cfg_we = 1'b0; credit_vld = 1'b0;
    cfg_port = '0; cfg_leaf = '0; cfg_dport = '0; credit_port = '0; credit_cnt = '0;
    in_tvalid = '1; in_tdata = '0;
    #12;
    chk("rst_pkt_out", 64'(pkt_out), 64'd0);
    chk("rst_tready", 64'(in_tready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);

    // two configured ports alternate, port 0 first
    reset_dut();
    ap_start = 1'b1; pkt_rdy = 1'b1;
    cfg_wr(0, 3, 1);
    cfg_wr(1, 5, 2);
    for (int k = 0; k < 4; k++) begin
      sb_q.push_back(mkpkt(3, 1, k, word(0, k)));
      sb_q.push_back(mkpkt(5, 2, k, word(1, k)));
    end
    limit[0] = 4; limit[1] = 4;
    drive_src();
    step();
    chk("first_pkt", 64'(pkt_out), 64'h1_3100_D000_0000);
    end_phase("alternate", 30);

    // unconfigured port 0 never granted
    reset_dut();
    ap_start = 1'b1; pkt_rdy = 1'b1;
    cfg_wr(1, 5, 2);
    for (int k = 0; k < 20; k++) sb_q.push_back(mkpkt(5, 2, k, word(1, k)));
    limit[0] = 20; limit[1] = 20;
    drive_src();
    for (int c = 0; c < 22; c++) begin
      step();
      chk("unconfigured_tready0", 64'(in_tready[0]), 64'd0);
    end
    end_phase("unconfigured", 10);

    // credit exhaustion, ignored bad port, return, and net return+accept
    reset_dut();
    ap_start = 1'b1; pkt_rdy = 1'b1;
    cfg_wr(0, 3, 1);
    for (int k = 0; k < 128; k++) sb_q.push_back(mkpkt(3, 1, k % 128, word(0, k)));
    limit[0] = 300;
    drive_src();
    begin
      int n = 0;
      while (sent[0] < 128 && n < 400) begin step(); n++; end
    end
    repeat (5) step();
    chk("credit_block_cnt", 64'(sent[0]), 64'd128);
    chk("credit_block_tready", 64'(in_tready[0]), 64'd0);
    credit_vld = 1'b1; credit_port = 4'd2; credit_cnt = 8'd64;
    step();
    credit_vld = 1'b0;
    repeat (3) step();
    chk("bad_credit_port", 64'(sent[0]), 64'd128);
    for (int k = 128; k < 193; k++) sb_q.push_back(mkpkt(3, 1, k % 128, word(0, k)));
    credit_vld = 1'b1; credit_port = 4'd0; credit_cnt = 8'd64;
    step();
    credit_vld = 1'b0;
    step();
    // 63 left: a return of 1 with an accept keeps it at 63
    credit_vld = 1'b1; credit_cnt = 8'd1;
    step();
    credit_vld = 1'b0;
    chk("accept_with_return", 64'(last_acc[0]), 64'd1);
    repeat (80) step();
    chk("credit_net_total", 64'(sent[0]), 64'd193);
    chk("credit_reblock_tready", 64'(in_tready[0]), 64'd0);
    end_phase("credit", 10);

    // back-pressure holds the packet, release gives next packet a cycle later
    reset_dut();
    ap_start = 1'b1; pkt_rdy = 1'b0;
    cfg_wr(0, 3, 1);
    for (int k = 0; k < 10; k++) sb_q.push_back(mkpkt(3, 1, k, word(0, k)));
    limit[0] = 10;
    drive_src();
    wait_valid(10);
    for (int c = 0; c < 5; c++) begin
      step();
      chk("stall_hold", 64'(pkt_out), 64'(mkpkt(3, 1, 0, word(0, 0))));
      chk("stall_tready", 64'(in_tready), 64'd0);
    end
    pkt_rdy = 1'b1;
    #1;
    chk("resume_tready", 64'(in_tready), 64'd1);
    step();
    chk("resume_next", 64'(pkt_out), 64'(mkpkt(3, 1, 1, word(0, 1))));
    end_phase("stall", 20);

    // graceful drain then restart
    reset_dut();
    ap_start = 1'b1; pkt_rdy = 1'b0;
    cfg_wr(0, 3, 1);
    for (int k = 0; k < 3; k++) sb_q.push_back(mkpkt(3, 1, k, word(0, k)));
    limit[0] = 3;
    drive_src();
    wait_valid(10);
    ap_start = 1'b0;
    step();
    for (int c = 0; c < 3; c++) begin
      chk("drain_busy", 64'(busy), 64'd1);
      chk("drain_tready", 64'(in_tready), 64'd0);
      step();
    end
    pkt_rdy = 1'b1;
    step();
    chk("idle_busy", 64'(busy), 64'd0);
    chk("idle_pkt_valid", 64'(pkt_out[48]), 64'd0);
    for (int c = 0; c < 2; c++) begin
      chk("idle_tready", 64'(in_tready), 64'd0);
      step();
    end
    ap_start = 1'b1;
    end_phase("drain_restart", 20);

    // asynchronous reset mid-stream
    reset_dut();
    ap_start = 1'b1; pkt_rdy = 1'b1;
    mon_en = 1'b0;
    cfg_wr(0, 3, 1);
    cfg_wr(1, 5, 2);
    limit[0] = 50; limit[1] = 50;
    drive_src();
    repeat (7) step();
    #2;
    ap_rst_n = 1'b0;
    #1;
    chk("async_rst_pkt_out", 64'(pkt_out), 64'd0);
    chk("async_rst_tready", 64'(in_tready), 64'd0);
    chk("async_rst_busy", 64'(busy), 64'd0);
    reset_dut();
    mon_en = 1'b1;
    ap_start = 1'b1; pkt_rdy = 1'b1;
    limit[0] = 2; limit[1] = 2;
    drive_src();
    for (int c = 0; c < 3; c++) begin
      step();
      chk("cfg_cleared_tready", 64'(in_tready), 64'd0);
    end
    sb_q.push_back(mkpkt(3, 1, 0, word(0, 0)));
    sb_q.push_back(mkpkt(5, 2, 0, word(1, 0)));
    sb_q.push_back(mkpkt(3, 1, 1, word(0, 1)));
    sb_q.push_back(mkpkt(5, 2, 1, word(1, 1)));
    cfg_wr(0, 3, 1);
    cfg_wr(1, 5, 2);
    end_phase("post_reset", 20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
